// File: rtl/axi_lite_master_if.sv
// Memory-side AXI4 signal bundle for axi_lite_master; the master modport faces the core-side bridge,
// the slave modport faces the SRAM/SDRAM model or crossbar port.
interface axi_lite_master_if;
  logic        io_master_awvalid;
  logic        io_master_awready;
  logic [31:0] io_master_awaddr;
  logic [2:0]  io_master_awsize;
  logic [3:0]  io_master_awid;
  logic [7:0]  io_master_awlen;
  logic [1:0]  io_master_awburst;

  logic        io_master_wvalid;
  logic        io_master_wready;
  logic [31:0] io_master_wdata;
  logic [3:0]  io_master_wstrb;
  logic        io_master_wlast;

  logic        io_master_bvalid;
  logic        io_master_bready;
  logic [1:0]  io_master_bresp;
  logic [3:0]  io_master_bid;

  logic        io_master_arvalid;
  logic        io_master_arready;
  logic [31:0] io_master_araddr;
  logic [2:0]  io_master_arsize;
  logic [3:0]  io_master_arid;
  logic [7:0]  io_master_arlen;
  logic [1:0]  io_master_arburst;

  logic        io_master_rvalid;
  logic        io_master_rready;
  logic [31:0] io_master_rdata;
  logic [1:0]  io_master_rresp;
  logic        io_master_rlast;
  logic [3:0]  io_master_rid;

  modport master (
    output io_master_awvalid, io_master_awaddr, io_master_awsize, io_master_awid,
           io_master_awlen, io_master_awburst,
    input  io_master_awready,
    output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    input  io_master_wready,
    input  io_master_bvalid, io_master_bresp, io_master_bid,
    output io_master_bready,
    output io_master_arvalid, io_master_araddr, io_master_arsize, io_master_arid,
           io_master_arlen, io_master_arburst,
    input  io_master_arready,
    input  io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid,
    output io_master_rready
  );

  modport slave (
    input  io_master_awvalid, io_master_awaddr, io_master_awsize, io_master_awid,
           io_master_awlen, io_master_awburst,
    output io_master_awready,
    input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
    output io_master_wready,
    output io_master_bvalid, io_master_bresp, io_master_bid,
    input  io_master_bready,
    input  io_master_arvalid, io_master_araddr, io_master_arsize, io_master_arid,
           io_master_arlen, io_master_arburst,
    output io_master_arready,
    output io_master_rvalid, io_master_rdata, io_master_rresp, io_master_rlast, io_master_rid,
    input  io_master_rready
  );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding core load/store to single-beat AXI4 bridge; best case 3 cycles accept-to-response.
// One transaction in flight: req_ready only in IDLE, response held until resp_ready, R/B guarded by a watchdog.
module axi_lite_master #(
  parameter logic [3:0]  AXI_ID  = 4'h0,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic [2:0]  req_size,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  axi_lite_master_if.master axi
);
  localparam int unsigned TLIM = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam int          CW   = $clog2(TLIM + 1);

  typedef enum logic [2:0] {IDLE, AR, R, AW_W, B, RESP} state_t;
  state_t state, state_nxt;

  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic [3:0]    wstrb_q;
  logic [2:0]    size_q;
  logic          arvalid_q, awvalid_q, wvalid_q, aw_done, w_done, err_q;
  logic [CW-1:0] wd_cnt;
  logic          accept, ar_hs, aw_hs, w_hs, r_hs, b_hs, in_wait, wd_hit;

  assign accept  = req_valid && (state == IDLE);
  assign ar_hs   = arvalid_q && axi.io_master_arready;
  assign aw_hs   = awvalid_q && axi.io_master_awready;
  assign w_hs    = wvalid_q && axi.io_master_wready;
  assign r_hs    = (state == R) && axi.io_master_rvalid;
  assign b_hs    = (state == B) && axi.io_master_bvalid;
  assign in_wait = (state == R) || (state == B);
  // Fires on the cycle the counter would reach TIMEOUT, so R/B last exactly TIMEOUT cycles.
  assign wd_hit  = (TIMEOUT != 0) && in_wait && (wd_cnt == CW'(TLIM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = req_wen ? AW_W : AR;
      AR:      if (ar_hs) state_nxt = R;
      R:       if (r_hs || wd_hit) state_nxt = RESP;
      AW_W:    if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = B;
      B:       if (b_hs || wd_hit) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      size_q    <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      if (accept) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
        size_q    <= req_size;
        arvalid_q <= !req_wen;
        awvalid_q <= req_wen;
        wvalid_q  <= req_wen;
      end
      if (ar_hs) arvalid_q <= 1'b0;
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;

      if (state == AW_W && state_nxt != AW_W) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if (r_hs) begin
        rdata_q <= axi.io_master_rdata;
        err_q   <= (axi.io_master_rresp != 2'b00);
      end else if (b_hs) begin
        rdata_q <= '0;
        err_q   <= (axi.io_master_bresp != 2'b00);
      end else if (wd_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end

      wd_cnt <= in_wait ? wd_cnt + CW'(1) : '0;
    end
  end

  // req_ready is forced low while reset is held, even though the state already reads IDLE.
  assign req_ready  = reset && (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign axi.io_master_awvalid = awvalid_q;
  assign axi.io_master_awaddr  = addr_q;
  assign axi.io_master_awsize  = size_q;
  assign axi.io_master_awid    = AXI_ID;
  assign axi.io_master_awlen   = 8'h00;
  assign axi.io_master_awburst = 2'b01;
  assign axi.io_master_wvalid  = wvalid_q;
  assign axi.io_master_wdata   = wdata_q;
  assign axi.io_master_wstrb   = wstrb_q;
  assign axi.io_master_wlast   = 1'b1;
  assign axi.io_master_bready  = (state == B);
  assign axi.io_master_arvalid = arvalid_q;
  assign axi.io_master_araddr  = addr_q;
  assign axi.io_master_arsize  = size_q;
  assign axi.io_master_arid    = AXI_ID;
  assign axi.io_master_arlen   = 8'h00;
  assign axi.io_master_arburst = 2'b01;
  assign axi.io_master_rready  = (state == R);

  logic unused_axi;
  assign unused_axi = ^{axi.io_master_bid, axi.io_master_rid, axi.io_master_rlast};
endmodule

// File: tb/tb_axi_lite_master.sv
// Bench for axi_lite_master: directed cases plus randomized transactions against a cycle-count model;
// the bench acts as core and as AXI slave, all activity on the falling clock edge.
module tb_axi_lite_master;
  localparam int         TMO = 8;
  localparam logic [3:0] ID  = 4'h5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic [2:0]  req_size = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0, n_fail = 0, cyc = 0;
  int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;

  always #5 clk = ~clk;

  axi_lite_master_if axi();

  axi_lite_master #(.AXI_ID(ID), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .req_size   (req_size),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .axi        (axi)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (axi.io_master_arvalid && axi.io_master_arready) ar_cnt <= ar_cnt + 1;
    if (axi.io_master_awvalid && axi.io_master_awready) aw_cnt <= aw_cnt + 1;
    if (axi.io_master_wvalid && axi.io_master_wready)   w_cnt  <= w_cnt + 1;
    if (axi.io_master_rvalid && axi.io_master_rready)   r_cnt  <= r_cnt + 1;
    if (axi.io_master_bvalid && axi.io_master_bready)   b_cnt  <= b_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Channel selector: 0 = AR, 1 = AW, 2 = W.
  function automatic logic ch_valid(input int ch);
    case (ch)
      0:       return axi.io_master_arvalid;
      1:       return axi.io_master_awvalid;
      default: return axi.io_master_wvalid;
    endcase
  endfunction

  function automatic logic [35:0] ch_pay(input int ch);
    case (ch)
      0:       return {1'b0, axi.io_master_arsize, axi.io_master_araddr};
      1:       return {1'b0, axi.io_master_awsize, axi.io_master_awaddr};
      default: return {axi.io_master_wstrb, axi.io_master_wdata};
    endcase
  endfunction

  task automatic set_ready(input int ch, input logic v);
    case (ch)
      0:       axi.io_master_arready = v;
      1:       axi.io_master_awready = v;
      default: axi.io_master_wready  = v;
    endcase
  endtask

  task automatic slave_chan(input int ch, input int dly, output logic [35:0] pay);
    string nm;
    bit seen, stable;
    case (ch)
      0:       nm = "ar";
      1:       nm = "aw";
      default: nm = "w";
    endcase
    seen = 1'b0;
    stable = 1'b1;
    pay = '0;
    for (int i = 0; i < 20; i++) begin
      if (ch_valid(ch)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({nm, "_valid_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      pay = ch_pay(ch);
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        if (!ch_valid(ch) || ch_pay(ch) !== pay) stable = 1'b0;
      end
      set_ready(ch, 1'b1);
      @(negedge clk);
      set_ready(ch, 1'b0);
      check({nm, "_held"}, 64'(stable), 64'd1);
      check({nm, "_valid_drop"}, 64'(ch_valid(ch)), 64'd0);
    end
  endtask

  task automatic slave_rsp(input bit is_read, input int dly, input logic [1:0] code,
                           input logic [31:0] data);
    bit hs;
    hs = 1'b0;
    if (dly >= 0) begin
      repeat (dly) @(negedge clk);
      if (is_read) begin
        axi.io_master_rvalid = 1'b1;
        axi.io_master_rresp  = code;
        axi.io_master_rdata  = data;
        axi.io_master_rlast  = 1'b1;
        axi.io_master_rid    = ID;
      end else begin
        axi.io_master_bvalid = 1'b1;
        axi.io_master_bresp  = code;
        axi.io_master_bid    = ID;
      end
      for (int i = 0; i < 20; i++) begin
        hs = is_read ? axi.io_master_rready : axi.io_master_bready;
        @(negedge clk);
        if (hs) break;
      end
      check("rsp_taken", 64'(hs), 64'd1);
      axi.io_master_rvalid = 1'b0;
      axi.io_master_bvalid = 1'b0;
      axi.io_master_rresp  = 2'b00;
      axi.io_master_bresp  = 2'b00;
      axi.io_master_rlast  = 1'b0;
      axi.io_master_rdata  = '0;
    end
  endtask

  task automatic send_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [2:0] size, output int t0);
    bit acc, rdy;
    acc = 1'b0;
    req_wen = wen;
    req_addr = addr;
    req_wdata = wdata;
    req_wstrb = wstrb;
    req_size = size;
    req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rdy = req_ready;
      @(negedge clk);
      if (rdy) begin
        acc = 1'b1;
        break;
      end
    end
    req_valid = 1'b0;
    check("req_accept", 64'(acc), 64'd1);
    t0 = cyc;
  endtask

  task automatic get_resp(input int hold, input int t0, output logic [31:0] data,
                          output logic err, output int lat);
    bit seen, stable;
    seen = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("resp_seen", 64'(seen), 64'd1);
    lat  = cyc - t0 + 1;
    data = resp_rdata;
    err  = resp_err;
    if (req_ready || axi.io_master_rready || axi.io_master_bready) stable = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== data || resp_err !== err || req_ready) stable = 1'b0;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_held", 64'(stable), 64'd1);
    check("resp_release", 64'({resp_valid, req_ready}), 64'(2'b01));
  endtask

  // Reference: latency = 3 + address-phase wait + response wait; a missing response costs TMO cycles in R/B.
  task automatic run_txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [2:0] size, input int d_a,
                         input int d_w, input int d_r, input logic [1:0] code,
                         input logic [31:0] sdata, input int hold);
    int t0, path, exp_lat, lat, n_ar, n_aw, n_w, n_r, n_b;
    bit tmo;
    logic [31:0] exp_data, got_data;
    logic exp_err, got_err;
    logic [35:0] pa, pw;
    path     = (wen && d_w > d_a) ? d_w : d_a;
    tmo      = (d_r < 0) || (d_r >= TMO);
    exp_lat  = tmo ? 2 + path + TMO : 3 + path + d_r;
    exp_err  = tmo || (code != 2'b00);
    exp_data = (wen || tmo) ? 32'h0 : sdata;
    n_ar = ar_cnt; n_aw = aw_cnt; n_w = w_cnt; n_r = r_cnt; n_b = b_cnt;

    send_req(wen, addr, wdata, wstrb, size, t0);
    check("xvalid_cycle1",
          64'({axi.io_master_awvalid, axi.io_master_wvalid, axi.io_master_arvalid}),
          wen ? 64'(3'b110) : 64'(3'b001));
    if (wen) begin
      fork
        slave_chan(1, d_a, pa);
        slave_chan(2, d_w, pw);
      join
      check("awaddr", 64'(pa[31:0]), 64'(addr));
      check("awsize", 64'(pa[34:32]), 64'(size));
      check("wdata", 64'(pw[31:0]), 64'(wdata));
      check("wstrb", 64'(pw[35:32]), 64'(wstrb));
    end else begin
      slave_chan(0, d_a, pa);
      check("araddr", 64'(pa[31:0]), 64'(addr));
      check("arsize", 64'(pa[34:32]), 64'(size));
    end
    slave_rsp(!wen, tmo ? -1 : d_r, code, sdata);
    get_resp(hold, t0, got_data, got_err, lat);
    check("resp_rdata", 64'(got_data), 64'(exp_data));
    check("resp_err", 64'(got_err), 64'(exp_err));
    check("resp_latency", 64'(lat), 64'(exp_lat));
    check("hs_counts",
          64'({8'(ar_cnt - n_ar), 8'(aw_cnt - n_aw), 8'(w_cnt - n_w), 8'(r_cnt - n_r), 8'(b_cnt - n_b)}),
          64'({8'(!wen), 8'(wen), 8'(wen), 8'(!wen && !tmo), 8'(wen && !tmo)}));
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int t0, da, dw, dr, hold;
    logic rw;
    logic [35:0] pa, pw;

    axi.io_master_awready = 1'b0;
    axi.io_master_wready  = 1'b0;
    axi.io_master_arready = 1'b0;
    axi.io_master_bvalid  = 1'b0;
    axi.io_master_bresp   = 2'b00;
    axi.io_master_bid     = 4'h0;
    axi.io_master_rvalid  = 1'b0;
    axi.io_master_rdata   = '0;
    axi.io_master_rresp   = 2'b00;
    axi.io_master_rlast   = 1'b0;
    axi.io_master_rid     = 4'h0;

    repeat (3) @(negedge clk);
    check("rst_handshakes",
          64'({req_ready, resp_valid, axi.io_master_arvalid, axi.io_master_awvalid,
               axi.io_master_wvalid, axi.io_master_rready, axi.io_master_bready}), 64'd0);
    check("rst_regs", 64'({resp_err, resp_rdata, axi.io_master_araddr, axi.io_master_wstrb}), 64'd0);
    check("consts",
          64'({axi.io_master_arid, axi.io_master_awid, axi.io_master_arlen, axi.io_master_awlen,
               axi.io_master_arburst, axi.io_master_awburst, axi.io_master_wlast}),
          64'({ID, ID, 8'h00, 8'h00, 2'b01, 2'b01, 1'b1}));
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 64'(req_ready), 64'd1);

    run_txn(1'b0, 32'h8000_0004, 32'h0, 4'h0, 3'd2, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0);
    run_txn(1'b1, 32'h8000_0010, 32'h1234_5678, 4'b0011, 3'd2, 2, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1'b0, 32'h8000_0100, 32'h0, 4'h0, 3'd2, 1, 0, 1, 2'b10, 32'hCAFE_F00D, 1);
    run_txn(1'b1, 32'h8000_0200, 32'hA5A5_5A5A, 4'hF, 3'd2, 0, 1, 2, 2'b11, 32'h0, 0);
    run_txn(1'b0, 32'h8000_0300, 32'h0, 4'h0, 3'd2, 0, 0, -1, 2'b00, 32'h1111_1111, 0);
    run_txn(1'b0, 32'h8000_0400, 32'h0, 4'h0, 3'd1, 0, 0, 3, 2'b00, 32'h0BAD_F00D, 5);

    // Reset asserted between clock edges while waiting for B.
    send_req(1'b1, 32'h8000_0500, 32'h5555_AAAA, 4'hF, 3'd2, t0);
    fork
      slave_chan(1, 0, pa);
      slave_chan(2, 0, pw);
    join
    check("in_b_state", 64'({axi.io_master_bready, pa[31:0], pw[31:0]}),
          64'({1'b1, 32'h8000_0500, 32'h5555_AAAA}));
    #2 reset = 1'b0;
    #1;
    check("arst_drop",
          64'({req_ready, resp_valid, axi.io_master_arvalid, axi.io_master_awvalid,
               axi.io_master_wvalid, axi.io_master_rready, axi.io_master_bready}), 64'd0);
    check("arst_regs", 64'({resp_rdata, axi.io_master_awaddr}), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 64'({req_ready, resp_valid, axi.io_master_bready}), 64'(3'b100));

    for (int k = 0; k < 40; k++) begin
      rw   = 1'($urandom_range(0, 1));
      da   = int'($urandom_range(0, 3));
      dw   = int'($urandom_range(0, 3));
      hold = int'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) dr = -1;
      else                           dr = int'($urandom_range(0, 5));
      run_txn(rw, $urandom(), $urandom(), 4'($urandom()), 3'($urandom_range(0, 2)),
              da, dw, dr, 2'($urandom()), $urandom(), hold);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
